rr_mux_arbiter_41: RTL and testbench

- Round-robin arbiter that shares one 4:1 mux path between four requesters.
- Drives the mux select (2-bit, value n selects input n) and a one-hot grant.
- Registers the selected requester's data word onto a single output bus.
- A time quantum stops one requester holding the path while others wait.

---
 rtl/rr_mux_arbiter_41.sv | 123 ++++++++++++
 tb/tb_rr_mux_arbiter_41.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter_41.sv
// Round-robin arbiter sharing one 4:1 mux path between four requesters.
// A quantum limits how long one owner holds the path while others wait.
module rr_mux_arbiter_41 #(
   parameter int W       = 8,
   parameter int QUANTUM = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [3:0]     req,
   input  logic [4*W-1:0] din,
   output logic [3:0]     gnt,
   output logic [1:0]     sel,
   output logic           busy,
   output logic [W-1:0]   dout,
   output logic           dout_valid
);

   localparam int            CW      = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(QUANTUM - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t              state, state_nx;
   logic [CW-1:0]       cnt, cnt_nx;
   logic [1:0]          last, last_nx, sel_nx;
   logic [3:0]          gnt_nx;
   logic [3:0][W-1:0]   din_lane;
   logic [W-1:0]        dout_mux;
   logic                found;
   logic [1:0]          win;

   for (genvar n = 0; n < 4; n++) begin : g_lane
      assign din_lane[n] = din[n*W +: W];
   end

   // Search last+4 down to last+1 so the highest-priority hit lands last;
   // last itself sits at lowest priority, which is how a preempted owner rejoins.
   always_comb begin
      logic [1:0] idx;
      found = 1'b0;
      win   = last;
      idx   = last;
      for (int i = 4; i >= 1; i--) begin
         idx = last + 2'(i);
         if (req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         gnt   <= '0;
         sel   <= '0;
         cnt   <= '0;
         last  <= 2'd3;
      end else begin
         state <= state_nx;
         gnt   <= gnt_nx;
         sel   <= sel_nx;
         cnt   <= cnt_nx;
         last  <= last_nx;
      end
   end

   always_comb begin
      state_nx = state;
      gnt_nx   = gnt;
      sel_nx   = sel;
      cnt_nx   = cnt;
      last_nx  = last;
      case (state)
         IDLE: begin
            if (found) begin
               state_nx = GRANT;
               gnt_nx   = 4'b0001 << win;
               sel_nx   = win;
               cnt_nx   = '0;
               last_nx  = win;
            end
         end
         GRANT: begin
            if (!req[sel] || (cnt == CNT_MAX && |(req & ~gnt))) begin
               if (found) begin
                  gnt_nx  = 4'b0001 << win;
                  sel_nx  = win;
                  cnt_nx  = '0;
                  last_nx = win;
               end else begin
                  state_nx = IDLE;
                  gnt_nx   = '0;
               end
            end else if (cnt == CNT_MAX) begin
               cnt_nx = '0;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy     = |gnt;
      dout_mux = din_lane[sel];
   end

   // Capture uses the grant in force before the edge, so dout lags gnt by one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout       <= '0;
         dout_valid <= 1'b0;
      end else if (|gnt) begin
         dout       <= dout_mux;
         dout_valid <= 1'b1;
      end else begin
         dout_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rr_mux_arbiter_41.sv
// Directed table-driven bench for rr_mux_arbiter_41 (W=8, QUANTUM=8).
module tb_rr_mux_arbiter_41;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [31:0] din;
   logic [3:0]  gnt;
   logic [1:0]  sel;
   logic        busy;
   logic [7:0]  dout;
   logic        dout_valid;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [3:0] req;
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       busy;
      logic       dv;
      logic [7:0] dout;
   } vec_t;

   vec_t       vec[$];
   logic [7:0] lane_v [4] = '{8'h11, 8'h22, 8'hA5, 8'h44};

   rr_mux_arbiter_41 #(.W(8), .QUANTUM(8)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .din(din),
      .gnt(gnt), .sel(sel), .busy(busy), .dout(dout), .dout_valid(dout_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic void add(input logic [3:0] r, input logic [3:0] g, input logic [1:0] s,
                               input logic b, input logic v, input logic [7:0] d);
      vec_t e;
      e.req = r; e.gnt = g; e.sel = s; e.busy = b; e.dv = v; e.dout = d;
      vec.push_back(e);
   endfunction

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
         chk("busy_eq_or_gnt", 32'(busy), 32'(|gnt));
         if (busy) chk("gnt_at_sel", 32'(gnt[sel]), 32'd1);
      end
   end

   initial begin
      int o;
      din   = {lane_v[3], lane_v[2], lane_v[1], lane_v[0]};
      req   = 4'b0000;
      rst_n = 1'b0;

      // idle with no requests
      for (int i = 0; i < 5; i++) add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00);
      // lone requester 2 held for 20 edges; cnt wraps silently
      add(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 8'h00);
      for (int i = 1; i < 20; i++) add(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, 8'hA5);
      add(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b1, 8'hA5);
      add(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 8'hA5);
      // owner 1 releases while 3 waits: handoff without a gap
      add(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, 8'hA5);
      add(4'b1010, 4'b0010, 2'd1, 1'b1, 1'b1, 8'h22);
      add(4'b1010, 4'b0010, 2'd1, 1'b1, 1'b1, 8'h22);
      add(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1, 8'h22);
      add(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1, 8'h44);
      add(4'b0000, 4'b0000, 2'd3, 1'b0, 1'b1, 8'h44);
      add(4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0, 8'h44);
      // all four requesting: 8-cycle quanta in order 0,1,2,3,0
      for (int k = 0; k < 40; k++) begin
         o = (k / 8) % 4;
         add(4'b1111, 4'(1 << o), 2'(o), 1'b1, k != 0, (k == 0) ? 8'h44 : lane_v[((k - 1) / 8) % 4]);
      end
      // owner 0 released with nobody waiting: sel held at 0
      add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1, 8'h11);
      add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h11);

      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_sel", 32'(sel), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_dout", 32'(dout), 32'h0);
      chk("rst_dv", 32'(dout_valid), 32'h0);
      @(negedge clk) rst_n = 1'b1;

      foreach (vec[i]) begin
         @(negedge clk) req = vec[i].req;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vec[i].gnt));
         chk($sformatf("v%0d_sel", i), 32'(sel), 32'(vec[i].sel));
         chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vec[i].busy));
         chk($sformatf("v%0d_dv", i), 32'(dout_valid), 32'(vec[i].dv));
         chk($sformatf("v%0d_dout", i), 32'(dout), 32'(vec[i].dout));
      end

      // request pulse between edges in IDLE is never sampled
      #2 req = 4'b0001;
      #2 req = 4'b0000;
      @(posedge clk);
      #1;
      chk("glitch_gnt", 32'(gnt), 32'h0);
      chk("glitch_busy", 32'(busy), 32'h0);

      // async reset mid-grant to 2, then 0 wins first
      @(negedge clk) req = 4'b0101;
      @(posedge clk);
      #1;
      chk("pre_rst_gnt", 32'(gnt), 32'h4);
      chk("pre_rst_sel", 32'(sel), 32'h2);
      @(posedge clk);
      #1;
      chk("pre_rst_dout", 32'(dout), 32'hA5);
      #2 rst_n = 1'b0;
      #1;
      chk("async_gnt", 32'(gnt), 32'h0);
      chk("async_busy", 32'(busy), 32'h0);
      chk("async_sel", 32'(sel), 32'h0);
      chk("async_dv", 32'(dout_valid), 32'h0);
      chk("async_dout", 32'(dout), 32'h0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_gnt0", 32'(gnt), 32'h1);
      chk("post_rst_sel0", 32'(sel), 32'h0);
      @(negedge clk) req = 4'b0100;
      @(posedge clk);
      #1;
      chk("post_rst_gnt2", 32'(gnt), 32'h4);
      chk("post_rst_sel2", 32'(sel), 32'h2);
      chk("post_rst_dout", 32'(dout), 32'h11);
      chk("post_rst_dv", 32'(dout_valid), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
